// File: rtl/bcd_conv_scheduler_if.sv
// Request/result bundle for the shared binary-to-BCD converter.
// The master drives requests; the slave is the scheduler itself.
interface bcd_conv_scheduler_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 2,
    parameter int NREQ   = 2
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [DIGITS*4-1:0]   bcd;
    logic                  overload;

    modport master (
        output req, req_data,
        input  grant, busy, done, done_id, bcd, overload
    );

    modport slave (
        input  req, req_data,
        output grant, busy, done, done_id, bcd, overload
    );
endinterface

// File: rtl/bcd_conv_scheduler.sv
// Round-robin shared shift-add-3 binary-to-BCD converter.
// One conversion takes WIDTH cycles; results carry the requester id.
module bcd_conv_scheduler #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 2,
    parameter int NREQ   = 2
) (
    input logic                 clock,
    input logic                 reset,
    bcd_conv_scheduler_if.slave bus
);
    localparam int INT_DIGITS = (WIDTH + 2) / 3;
    localparam int BW   = INT_DIGITS * 4;
    localparam int SW   = BW + WIDTH;
    localparam int CW   = $clog2(WIDTH);
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAXD =
        ((DIGITS > INT_DIGITS) ? DIGITS : INT_DIGITS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [IDW-1:0]      done_id_q, done_id_d;
    logic [DIGITS*4-1:0] bcd_q, bcd_d;
    logic                ovl_q, ovl_d;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [SW-1:0]       sh_q, sh_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [SW-1:0]       sh_nxt;
    logic [MAXD*4-1:0]   full_w;
    logic [IDW-1:0]      winner;

    // One double-dabble iteration: correct nibbles, then shift.
    always_comb begin
        logic [SW-1:0] adj;
        adj = sh_q;
        for (int k = 0; k < INT_DIGITS; k++) begin
            if (adj[WIDTH+4*k +: 4] >= 4'd5) begin
                adj[WIDTH+4*k +: 4] = adj[WIDTH+4*k +: 4] + 4'd3;
            end
        end
        sh_nxt = adj << 1;
        full_w = '0;
        full_w[BW-1:0] = sh_nxt[SW-1 -: BW];
    end

    // Search upward from rr+1, wrapping, for the next requester.
    always_comb begin
        logic found;
        int   idx;
        winner = rr_q;
        found  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(rr_q) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        bcd_d     = bcd_q;
        ovl_d     = ovl_q;
        rr_d      = rr_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d         = SHIFT;
                    grant_d[winner] = 1'b1;
                    busy_d          = 1'b1;
                    rr_d            = winner;
                    sh_d            = {{BW{1'b0}},
                        bus.req_data[winner*WIDTH +: WIDTH]};
                    cnt_d           = '0;
                end
            end
            SHIFT: begin
                sh_d  = sh_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_id_d = rr_q;
                    bcd_d     = full_w[DIGITS*4-1:0];
                    ovl_d     = |(full_w >> (DIGITS * 4));
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            bcd_q     <= '0;
            ovl_q     <= 1'b0;
            rr_q      <= IDW'(NREQ - 1);
            sh_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            bcd_q     <= bcd_d;
            ovl_q     <= ovl_d;
            rr_q      <= rr_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.done_id  = done_id_q;
    assign bus.bcd      = bcd_q;
    assign bus.overload = ovl_q;
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler, WIDTH=8 DIGITS=2 NREQ=2.
// Table of single conversions plus hand-written multi-cycle sequences.
module tb_bcd_conv_scheduler;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 2;
    localparam int NREQ   = 2;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    bcd_conv_scheduler_if #(
        .WIDTH(WIDTH), .DIGITS(DIGITS), .NREQ(NREQ)
    ) bus ();

    bcd_conv_scheduler #(
        .WIDTH(WIDTH), .DIGITS(DIGITS), .NREQ(NREQ)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] eg;
        logic [7:0] eb;
        logic       eo;
        logic       ei;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h",
                     nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.req      = '0;
        bus.req_data = '0;
        reset        = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    // Assumes req is already driven; waits for grant then done.
    task automatic do_txn(input string nm,
                          input logic [1:0] eg,
                          input logic [7:0] eb,
                          input logic eo,
                          input logic ei,
                          input bit drop,
                          output int gcyc);
        int c;
        c = 0;
        while (bus.grant == '0 && c < 30) begin
            @(negedge clock);
            c++;
        end
        gcyc = c;
        check({nm, ".grant"}, 32'(bus.grant), 32'(eg));
        if (drop) bus.req = '0;
        c = 0;
        while (!bus.done && c < 30) begin
            @(negedge clock);
            c++;
        end
        check({nm, ".lat"}, 32'(c), 32'(WIDTH));
        check({nm, ".bcd"}, 32'(bus.bcd), 32'(eb));
        check({nm, ".ovl"}, 32'(bus.overload), 32'(eo));
        check({nm, ".id"}, 32'(bus.done_id), 32'(ei));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int cnt;
        logic [1:0] exp_g;
        checks   = 0;
        failures = 0;

        vecs[0] = '{2'b01, 8'd42,  8'd0,   2'b01, 8'h42, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 8'd99,  8'd0,   2'b01, 8'h99, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 8'd100, 8'd0,   2'b01, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 8'd255, 8'd0,   2'b01, 8'h55, 1'b1, 1'b0};
        vecs[4] = '{2'b10, 8'd0,   8'd200, 2'b10, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{2'b10, 8'd0,   8'd63,  2'b10, 8'h63, 1'b0, 1'b1};
        vecs[6] = '{2'b11, 8'd5,   8'd9,   2'b01, 8'h05, 1'b0, 1'b0};
        vecs[7] = '{2'b11, 8'd5,   8'd9,   2'b10, 8'h09, 1'b0, 1'b1};

        do_reset();
        check("rst.grant", 32'(bus.grant), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.bcd", 32'(bus.bcd), 32'd0);
        check("rst.ovl", 32'(bus.overload), 32'd0);

        for (int i = 0; i < 8; i++) begin
            bus.req_data = {vecs[i].d1, vecs[i].d0};
            bus.req      = vecs[i].req;
            do_txn($sformatf("vec%0d", i), vecs[i].eg,
                   vecs[i].eb, vecs[i].eo, vecs[i].ei, 1'b1, g);
            check($sformatf("vec%0d.glat", i), 32'(g), 32'd1);
            check($sformatf("vec%0d.busy", i),
                  32'(bus.busy), 32'd1);
            @(negedge clock);
            check($sformatf("vec%0d.busyoff", i),
                  32'(bus.busy), 32'd0);
        end

        // Both requesters held: grants alternate, no starvation.
        do_reset();
        bus.req_data = {8'd200, 8'd7};
        bus.req      = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            do_txn($sformatf("rr%0d", i), exp_g,
                   (i % 2 == 0) ? 8'h07 : 8'h00,
                   (i % 2 == 0) ? 1'b0 : 1'b1,
                   (i % 2 == 0) ? 1'b0 : 1'b1, 1'b0, g);
            check($sformatf("rr%0d.gap", i), 32'(g),
                  (i == 0) ? 32'd1 : 32'd2);
        end
        bus.req = '0;
        repeat (3) @(negedge clock);

        // Requester 1 raised mid-conversion then dropped: lost.
        bus.req_data = {8'd34, 8'd12};
        bus.req      = 2'b01;
        @(negedge clock);
        check("lost.grant0", 32'(bus.grant), 32'b01);
        bus.req = 2'b00;
        repeat (2) @(negedge clock);
        bus.req = 2'b10;
        repeat (3) @(negedge clock);
        bus.req = 2'b00;
        cnt = 0;
        while (!bus.done && cnt < 30) begin
            @(negedge clock);
            cnt++;
        end
        check("lost.bcd", 32'(bus.bcd), 32'h12);
        check("lost.id", 32'(bus.done_id), 32'd0);
        cnt = 0;
        repeat (15) begin
            @(negedge clock);
            if (bus.grant != '0 || bus.done) cnt++;
        end
        check("lost.quiet", 32'(cnt), 32'd0);

        // Operand changed after grant: captured value wins.
        bus.req_data = {8'd0, 8'd58};
        bus.req      = 2'b01;
        @(negedge clock);
        check("cap.grant", 32'(bus.grant), 32'b01);
        @(negedge clock);
        bus.req_data = {8'd0, 8'd200};
        bus.req      = 2'b00;
        cnt = 0;
        while (!bus.done && cnt < 30) begin
            @(negedge clock);
            cnt++;
        end
        check("cap.bcd", 32'(bus.bcd), 32'h58);
        check("cap.ovl", 32'(bus.overload), 32'd0);
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.bcd != 8'h58) cnt++;
        end
        check("cap.hold", 32'(cnt), 32'd0);

        // Reset in the 4th SHIFT cycle aborts with no done.
        bus.req_data = {8'd0, 8'd77};
        bus.req      = 2'b01;
        @(negedge clock);
        check("abort.grant", 32'(bus.grant), 32'b01);
        bus.req = 2'b00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.grant0", 32'(bus.grant), 32'd0);
        check("abort.bcd", 32'(bus.bcd), 32'd0);
        check("abort.ovl", 32'(bus.overload), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (bus.done || bus.busy) cnt++;
        end
        check("abort.quiet", 32'(cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
